// File: rtl/oc_bank_arbiter.sv
// oc_bank_arbiter: per-bank round-robin operand read arbiter over a 4x8x32 register file with writeback port.
// Define OC_BANK_WB_BYPASS_EN to forward writeback data instead of blocking the written bank.
module oc_bank_arbiter #(
  parameter int NUM_OC = 4,
  localparam int NS = 2 * NUM_OC,
  localparam int OCID_W = $clog2(NS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NS-1:0]     req_vld,
  input  logic [5*NS-1:0]   req_reg_id,
  output logic [NS-1:0]     req_ack,
  input  logic              wb_we,
  input  logic [4:0]        wb_reg_id,
  input  logic [31:0]       wb_data,
  output logic [31:0]       bk_0_data,
  output logic [31:0]       bk_1_data,
  output logic [31:0]       bk_2_data,
  output logic [31:0]       bk_3_data,
  output logic              bk_0_vld,
  output logic              bk_1_vld,
  output logic              bk_2_vld,
  output logic              bk_3_vld,
  output logic [OCID_W-1:0] bk_0_ocid,
  output logic [OCID_W-1:0] bk_1_ocid,
  output logic [OCID_W-1:0] bk_2_ocid,
  output logic [OCID_W-1:0] bk_3_ocid,
  output logic              bk_0_bz,
  output logic              bk_1_bz,
  output logic              bk_2_bz,
  output logic              bk_3_bz
);
  logic [31:0]       rf_q [4][8];
  logic [31:0]       data_q [4];
  logic [OCID_W-1:0] ocid_q [4];
  logic [OCID_W-1:0] rr_q [4];
  logic [OCID_W-1:0] rr_d [4];
  logic [OCID_W-1:0] gsel [4];
  logic [2:0]        row [4];
  logic [31:0]       rdat [4];
  logic [3:0]        vld_q, bz_q, bz_d, gnt, fnd, blk;
  int                s;
  always_comb begin
    req_ack = '0;
    s = 0;
    for (int b = 0; b < 4; b++) begin
      fnd[b] = 1'b0;
      gsel[b] = '0;
      for (int i = 0; i < NS; i++) begin
        s = (int'(rr_q[b]) + i) % NS;
        if (!fnd[b] && req_vld[s] && req_reg_id[5*s+3 +: 2] == 2'(b)) begin
          fnd[b] = 1'b1;
          gsel[b] = OCID_W'(s);
        end
      end
`ifdef OC_BANK_WB_BYPASS_EN
      blk[b] = 1'b0;
`else
      blk[b] = wb_we && wb_reg_id[4:3] == 2'(b);
`endif
      gnt[b] = fnd[b] && !blk[b] && rst;
      bz_d[b] = fnd[b] && blk[b];
      rr_d[b] = OCID_W'((int'(gsel[b]) + 1) % NS);
      row[b] = req_reg_id[5*int'(gsel[b]) +: 3];
`ifdef OC_BANK_WB_BYPASS_EN
      rdat[b] = (wb_we && wb_reg_id == {2'(b), row[b]}) ? wb_data : rf_q[b][row[b]];
`else
      rdat[b] = rf_q[b][row[b]];
`endif
      if (gnt[b]) req_ack[gsel[b]] = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q <= '0;
      bz_q <= '0;
      for (int b = 0; b < 4; b++) begin
        data_q[b] <= '0;
        ocid_q[b] <= '0;
        rr_q[b] <= '0;
        for (int r = 0; r < 8; r++) rf_q[b][r] <= '0;
      end
    end else begin
      vld_q <= gnt;
      bz_q <= bz_d;
      for (int b = 0; b < 4; b++) begin
        if (gnt[b]) begin
          data_q[b] <= rdat[b];
          ocid_q[b] <= gsel[b];
          rr_q[b] <= rr_d[b];
        end
      end
      if (wb_we) rf_q[wb_reg_id[4:3]][wb_reg_id[2:0]] <= wb_data;
    end
  end
  assign {bk_3_vld, bk_2_vld, bk_1_vld, bk_0_vld} = vld_q;
  assign {bk_3_bz, bk_2_bz, bk_1_bz, bk_0_bz} = bz_q;
  assign bk_0_data = data_q[0];
  assign bk_1_data = data_q[1];
  assign bk_2_data = data_q[2];
  assign bk_3_data = data_q[3];
  assign bk_0_ocid = ocid_q[0];
  assign bk_1_ocid = ocid_q[1];
  assign bk_2_ocid = ocid_q[2];
  assign bk_3_ocid = ocid_q[3];
endmodule
